ram_arbiter: RTL and testbench

Arbitrates the single port of the main RAM (`ram_main`) between the core's instruction-fetch port and its load/store port. It sits between the core and the RAM inside `top`, runs on the system clock, and keeps exactly one RAM transaction in flight. Each request gets a grant and then a response after a fixed RAM read latency.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arb_select.sv | 31 +++
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the main-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [MASK_W-1:0] MASK_ALL  = 4'b1111;
    localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_arb_select.sv
// Winner selection between instruction and data ports.
// Macro RAM_ARB_ROUND_ROBIN_EN: alternate on contention using last_owner;
// otherwise the data port always wins.
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   issue_slot,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    output logic   grant,
    output owner_t winner
);

    // Pick a winner among the pending requests in an issue slot
    always_comb begin
        grant  = issue_slot && (i_req || d_req);
        winner = OWNER_D;
        if (!d_req) begin
            winner = OWNER_I;
        end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        else if (i_req && (last_owner == OWNER_D)) begin
            winner = OWNER_I;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single main-RAM port between instruction fetch and load/store,
// keeping one transaction in flight with a fixed read latency.
// Macro RAM_ARB_ROUND_ROBIN_EN: round-robin on contention (default: D priority).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  sysClk,
    input  logic                  sysRes,
    input  logic                  iReq,
    input  logic [31:0]           iAddr,
    output logic                  iGnt,
    output logic                  iRvalid,
    output logic [31:0]           iRdata,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [3:0]            dMask,
    input  logic [31:0]           dAddr,
    input  logic [31:0]           dWdata,
    output logic                  dGnt,
    output logic                  dRvalid,
    output logic [31:0]           dRdata,
    output logic                  ramEn,
    output logic                  ramWe,
    output logic [3:0]            ramMask,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [31:0]           ramWdata,
    input  logic [31:0]           ramRdata
);

    localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             is_write_q, is_write_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    owner_t           last_owner_q, last_owner_d;
`endif

    logic   resp_slot;
    logic   issue_slot;
    logic   grant;
    owner_t winner;

    // Response cycle of the in-flight transaction doubles as the next issue slot
    always_comb begin
        resp_slot  = !sysRes && (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
        issue_slot = !sysRes && ((state_q == ST_IDLE) || resp_slot);
    end

    ram_arb_select u_select (
        .i_req      (iReq),
        .d_req      (dReq),
        .issue_slot (issue_slot),
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner_q),
`endif
        .grant      (grant),
        .winner     (winner)
    );

    // Next-state, RAM drive, grant and response generation
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        iGnt     = 1'b0;
        dGnt     = 1'b0;
        iRvalid  = 1'b0;
        dRvalid  = 1'b0;
        iRdata   = '0;
        dRdata   = '0;
        ramEn    = 1'b0;
        ramWe    = 1'b0;
        ramMask  = MASK_NONE;
        ramAddr  = '0;
        ramWdata = '0;

        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
            end
        end

        if (resp_slot) begin
            if (owner_q == OWNER_I) begin
                iRvalid = 1'b1;
                iRdata  = ramRdata;
            end else begin
                dRvalid = 1'b1;
                dRdata  = is_write_q ? '0 : ramRdata;
            end
        end

        if (grant) begin
            state_d = ST_BUSY;
            owner_d = winner;
            cnt_d   = CNT_W'(RAM_LATENCY);
            ramEn   = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_owner_d = winner;
`endif
            if (winner == OWNER_D) begin
                dGnt       = 1'b1;
                ramWe      = dWe;
                ramMask    = dMask;
                ramAddr    = ADDR_WIDTH'(dAddr);
                ramWdata   = dWdata;
                is_write_d = dWe;
            end else begin
                iGnt       = 1'b1;
                ramMask    = MASK_ALL;
                ramAddr    = ADDR_WIDTH'(iAddr);
                is_write_d = 1'b0;
            end
        end
    end

    // State registers; reset drops any in-flight transaction
    always_ff @(posedge sysClk or posedge sysRes) begin
        if (sysRes) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_I;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWNER_I;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: instance a at latency 1, instance b at latency 3.
module tb_ram_arbiter;

    typedef struct {
        logic        port;   // 0 = I, 1 = D
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t e_a, e_b;

    // ---------------- instance a (latency 1)
    logic        a_iReq, a_iGnt, a_iRvalid, a_dReq, a_dWe, a_dGnt, a_dRvalid;
    logic        a_ramEn, a_ramWe;
    logic [3:0]  a_dMask, a_ramMask;
    logic [31:0] a_iAddr, a_iRdata, a_dAddr, a_dWdata, a_dRdata;
    logic [31:0] a_ramAddr, a_ramWdata, a_ramRdata;

    // ---------------- instance b (latency 3)
    logic        b_iReq, b_iGnt, b_iRvalid, b_dReq, b_dWe, b_dGnt, b_dRvalid;
    logic        b_ramEn, b_ramWe;
    logic [3:0]  b_dMask, b_ramMask;
    logic [31:0] b_iAddr, b_iRdata, b_dAddr, b_dWdata, b_dRdata;
    logic [31:0] b_ramAddr, b_ramWdata, b_ramRdata;

    ram_arbiter #(.ADDR_WIDTH(32), .RAM_LATENCY(1)) u_dut_a (
        .sysClk(clk), .sysRes(rst),
        .iReq(a_iReq), .iAddr(a_iAddr), .iGnt(a_iGnt), .iRvalid(a_iRvalid), .iRdata(a_iRdata),
        .dReq(a_dReq), .dWe(a_dWe), .dMask(a_dMask), .dAddr(a_dAddr), .dWdata(a_dWdata),
        .dGnt(a_dGnt), .dRvalid(a_dRvalid), .dRdata(a_dRdata),
        .ramEn(a_ramEn), .ramWe(a_ramWe), .ramMask(a_ramMask), .ramAddr(a_ramAddr),
        .ramWdata(a_ramWdata), .ramRdata(a_ramRdata)
    );

    ram_arbiter #(.ADDR_WIDTH(32), .RAM_LATENCY(3)) u_dut_b (
        .sysClk(clk), .sysRes(rst),
        .iReq(b_iReq), .iAddr(b_iAddr), .iGnt(b_iGnt), .iRvalid(b_iRvalid), .iRdata(b_iRdata),
        .dReq(b_dReq), .dWe(b_dWe), .dMask(b_dMask), .dAddr(b_dAddr), .dWdata(b_dWdata),
        .dGnt(b_dGnt), .dRvalid(b_dRvalid), .dRdata(b_dRdata),
        .ramEn(b_ramEn), .ramWe(b_ramWe), .ramMask(b_ramMask), .ramAddr(b_ramAddr),
        .ramWdata(b_ramWdata), .ramRdata(b_ramRdata)
    );

    logic [137:0] a_outs, b_outs;
    assign a_outs = {a_iGnt, a_iRvalid, a_iRdata, a_dGnt, a_dRvalid, a_dRdata,
                     a_ramEn, a_ramWe, a_ramMask, a_ramAddr, a_ramWdata};
    assign b_outs = {b_iGnt, b_iRvalid, b_iRdata, b_dGnt, b_dRvalid, b_dRdata,
                     b_ramEn, b_ramWe, b_ramMask, b_ramAddr, b_ramWdata};

    // ---------------- RAM models with backdoor preload
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] b_p1, b_p2;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_idx] <= pl_data;
        end else if (a_ramEn && a_ramWe) begin
            for (int k = 0; k < 4; k++)
                if (a_ramMask[k]) mem_a[a_ramAddr[9:2]][k*8 +: 8] <= a_ramWdata[k*8 +: 8];
        end
        a_ramRdata <= a_ramEn ? mem_a[a_ramAddr[9:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem_b[pl_idx] <= pl_data;
        end else if (b_ramEn && b_ramWe) begin
            for (int k = 0; k < 4; k++)
                if (b_ramMask[k]) mem_b[b_ramAddr[9:2]][k*8 +: 8] <= b_ramWdata[k*8 +: 8];
        end
        b_p1       <= b_ramEn ? mem_b[b_ramAddr[9:2]] : 32'h0;
        b_p2       <= b_p1;
        b_ramRdata <= b_p2;
    end

    // ---------------- response scoreboards
    always @(negedge clk) begin
        checks++;
        if (a_iRvalid && a_dRvalid) begin
            failures++;
            $display("FAIL a_rvalid_both: iRvalid=%b dRvalid=%b required at most one", a_iRvalid, a_dRvalid);
        end else if (a_iRvalid || a_dRvalid) begin
            if (sb_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_rvalid: cyc=%0d i=%b d=%b required none", cyc, a_iRvalid, a_dRvalid);
            end else begin
                e_a = sb_a.pop_front();
                if (a_dRvalid !== e_a.port || (a_dRvalid ? a_dRdata : a_iRdata) !== e_a.data || cyc != e_a.cyc) begin
                    failures++;
                    $display("FAIL a_response: port=%b data=%h cyc=%0d required port=%b data=%h cyc=%0d",
                             a_dRvalid, a_dRvalid ? a_dRdata : a_iRdata, cyc, e_a.port, e_a.data, e_a.cyc);
                end
            end
        end else if (a_iRdata !== 32'h0 || a_dRdata !== 32'h0) begin
            failures++;
            $display("FAIL a_rdata_idle: iRdata=%h dRdata=%h required 0", a_iRdata, a_dRdata);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (b_iRvalid && b_dRvalid) begin
            failures++;
            $display("FAIL b_rvalid_both: iRvalid=%b dRvalid=%b required at most one", b_iRvalid, b_dRvalid);
        end else if (b_iRvalid || b_dRvalid) begin
            if (sb_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_rvalid: cyc=%0d i=%b d=%b required none", cyc, b_iRvalid, b_dRvalid);
            end else begin
                e_b = sb_b.pop_front();
                if (b_dRvalid !== e_b.port || (b_dRvalid ? b_dRdata : b_iRdata) !== e_b.data || cyc != e_b.cyc) begin
                    failures++;
                    $display("FAIL b_response: port=%b data=%h cyc=%0d required port=%b data=%h cyc=%0d",
                             b_dRvalid, b_dRvalid ? b_dRdata : b_iRdata, cyc, e_b.port, e_b.data, e_b.cyc);
                end
            end
        end else if (b_iRdata !== 32'h0 || b_dRdata !== 32'h0) begin
            failures++;
            $display("FAIL b_rdata_idle: iRdata=%h dRdata=%h required 0", b_iRdata, b_dRdata);
        end
    end

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        tick();
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        sample();
        checks++;
        if (a_outs !== '0) begin
            failures++;
            $display("FAIL reset_a_outputs: got %h required 0", a_outs);
        end
        checks++;
        if (b_outs !== '0) begin
            failures++;
            $display("FAIL reset_b_outputs: got %h required 0", b_outs);
        end
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if (a_outs !== '0 || b_outs !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: a=%h b=%h required 0", a_outs, b_outs);
        end
    endtask

    task automatic test_single_fetch();
        preload(8'h10, 32'h0000_0013);
        tick();
        a_iReq  = 1'b1;
        a_iAddr = 32'h40;
        sample();
        checks++;
        if ({a_iGnt, a_dGnt, a_ramEn, a_ramWe, a_ramMask} !== 8'b1010_1111) begin
            failures++;
            $display("FAIL fetch_grant: gnt/en/we/mask=%b required 10101111",
                     {a_iGnt, a_dGnt, a_ramEn, a_ramWe, a_ramMask});
        end
        checks++;
        if (a_ramAddr !== 32'h40 || a_ramWdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_addr: ramAddr=%h ramWdata=%h required 00000040 00000000", a_ramAddr, a_ramWdata);
        end
        if (a_iGnt) sb_a.push_back('{1'b0, 32'h0000_0013, cyc + 1});
        tick();
        a_iReq = 1'b0;
        sample();
        checks++;
        if ({a_iRvalid, a_iRdata, a_ramEn} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            failures++;
            $display("FAIL fetch_response: rvalid=%b rdata=%h ramEn=%b required 1 00000013 0",
                     a_iRvalid, a_iRdata, a_ramEn);
        end
        tick();
        sample();
        checks++;
        if (a_outs !== '0) begin
            failures++;
            $display("FAIL fetch_idle_after: got %h required 0", a_outs);
        end
    endtask

    task automatic test_write_read();
        preload(8'h40, 32'h1122_3344);
        tick();
        a_dReq   = 1'b1;
        a_dWe    = 1'b1;
        a_dMask  = 4'b0011;
        a_dAddr  = 32'h100;
        a_dWdata = 32'hDEAD_BEEF;
        sample();
        checks++;
        if ({a_dGnt, a_iGnt, a_ramEn, a_ramWe, a_ramMask, a_ramAddr, a_ramWdata} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL write_grant: gnt=%b en=%b we=%b mask=%b addr=%h wdata=%h required 1 1 1 0011 00000100 deadbeef",
                     a_dGnt, a_ramEn, a_ramWe, a_ramMask, a_ramAddr, a_ramWdata);
        end
        if (a_dGnt) sb_a.push_back('{1'b1, 32'h0, cyc + 1});
        tick();
        a_dWe    = 1'b0;
        a_dMask  = 4'b0000;
        a_dWdata = 32'h0;
        sample();
        checks++;
        if ({a_dGnt, a_dRvalid, a_dRdata, a_ramWe} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL write_resp_read_grant: gnt=%b rvalid=%b rdata=%h we=%b required 1 1 00000000 0",
                     a_dGnt, a_dRvalid, a_dRdata, a_ramWe);
        end
        if (a_dGnt) sb_a.push_back('{1'b1, 32'h1122_BEEF, cyc + 1});
        tick();
        a_dReq = 1'b0;
        sample();
        checks++;
        if ({a_dRvalid, a_dRdata} !== {1'b1, 32'h1122_BEEF}) begin
            failures++;
            $display("FAIL read_back: rvalid=%b rdata=%h required 1 1122beef", a_dRvalid, a_dRdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [4];
        logic [1:0] got;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        preload(8'h80, 32'hA0A0_0001);
        preload(8'hC0, 32'hD0D0_0002);
        tick();
        a_iReq  = 1'b1;
        a_iAddr = 32'h200;
        a_dReq  = 1'b1;
        a_dWe   = 1'b0;
        a_dAddr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            sample();
            got = {a_iGnt, a_dGnt};
            checks++;
            if (got !== exp_seq[g]) begin
                failures++;
                $display("FAIL contention_grant_%0d: {iGnt,dGnt}=%b required %b", g, got, exp_seq[g]);
            end
            if (got == 2'b01) sb_a.push_back('{1'b1, 32'hD0D0_0002, cyc + 1});
            if (got == 2'b10) sb_a.push_back('{1'b0, 32'hA0A0_0001, cyc + 1});
            tick();
        end
        a_iReq = 1'b0;
        a_dReq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_latency();
        int n     = 0;
        int last  = 0;
        int first = 0;
        for (int k = 0; k < 4; k++) preload(8'(4 + k), 32'hB000_0000 + 32'(k));
        tick();
        b_iReq  = 1'b1;
        b_iAddr = 32'h10;
        first   = cyc;
        for (int budget = 0; budget < 40 && n < 4; budget++) begin
            sample();
            if (b_iGnt) begin
                sb_b.push_back('{1'b0, 32'hB000_0000 + 32'(n), cyc + 3});
                checks++;
                if (n == 0 && cyc != first) begin
                    failures++;
                    $display("FAIL latency_first_grant: cyc=%0d required %0d", cyc, first);
                end else if (n > 0 && cyc - last != 3) begin
                    failures++;
                    $display("FAIL latency_grant_spacing_%0d: %0d cycles required 3", n, cyc - last);
                end
                last = cyc;
                n++;
            end
            tick();
            if (n < 4) b_iAddr = 32'h10 + 32'(4 * n);
            else       b_iReq  = 1'b0;
        end
        b_iReq = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL latency_timeout: grants=%0d required 4", n);
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        int d_seen = 0;
        preload(8'h50, 32'hCAFE_0001);
        tick();
        b_dReq  = 1'b1;
        b_dWe   = 1'b0;
        b_dAddr = 32'h140;
        sample();
        checks++;
        if (b_dGnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_dgnt: dGnt=%b required 1", b_dGnt);
        end
        tick();
        b_dReq  = 1'b0;
        rst     = 1'b1;
        b_iReq  = 1'b1;
        b_iAddr = 32'h10;
        sample();
        checks++;
        if (b_outs !== '0 || a_outs !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: b=%h a=%h required 0", b_outs, a_outs);
        end
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if ({b_iGnt, b_dGnt, b_ramAddr} !== {1'b1, 1'b0, 32'h10}) begin
            failures++;
            $display("FAIL rst_mid_regrant: iGnt=%b dGnt=%b addr=%h required 1 0 00000010", b_iGnt, b_dGnt, b_ramAddr);
        end
        if (b_iGnt) sb_b.push_back('{1'b0, 32'hB000_0000, cyc + 3});
        tick();
        b_iReq = 1'b0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (b_dRvalid) d_seen++;
            tick();
        end
        checks++;
        if (d_seen != 0) begin
            failures++;
            $display("FAIL rst_mid_no_drvalid: dRvalid seen %0d times required 0", d_seen);
        end
    endtask

    initial begin
        a_iReq = 1'b0; a_iAddr = '0; a_dReq = 1'b0; a_dWe = 1'b0; a_dMask = '0; a_dAddr = '0; a_dWdata = '0;
        b_iReq = 1'b0; b_iAddr = '0; b_dReq = 1'b0; b_dWe = 1'b0; b_dMask = '0; b_dAddr = '0; b_dWdata = '0;

        test_reset();
        test_single_fetch();
        test_write_read();
        test_contention();
        test_latency();
        test_reset_mid();

        repeat (5) tick();
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending a=%0d b=%0d required 0", sb_a.size(), sb_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
